// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial, LSB-first WIDTH-bit adder with carry-in. An operand pair is
// accepted through a valid/ready start handshake. One result bit is produced
// per clock using a single carry flop. The finished sum, carry-out and
// two's-complement overflow flag are presented through a valid/ready result
// handshake.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start_valid  in   operand pair and carry_in are valid
//   start_ready  out  block can accept operands (IDLE only)
//   addend_a     in   first operand  [WIDTH-1:0]
//   addend_b     in   second operand [WIDTH-1:0]
//   carry_in     in   carry into bit 0
//   sum_valid    out  result is valid (DONE only)
//   sum_ready    in   consumer accepts the result
//   sum          out  addend_a + addend_b + carry_in mod 2^WIDTH
//   carry_out    out  carry out of bit WIDTH-1
//   overflow     out  carry into MSB XOR carry out of MSB
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] addend_a,
    input  logic [WIDTH-1:0] addend_b,
    input  logic             carry_in,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    // Counter has to be able to reach WIDTH, hence clog2(WIDTH+1).
    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [WIDTH-1:0]   opA_q,        opA_d;
    logic [WIDTH-1:0]   opB_q,        opB_d;
    logic               carry_q,      carry_d;
    logic [CW-1:0]      bitCnt_q,     bitCnt_d;
    logic [WIDTH-2:0]   sumShift_q,   sumShift_d;
    logic [WIDTH-1:0]   sum_q,        sum_d;
    logic               carryOut_q,   carryOut_d;
    logic               overflow_q,   overflow_d;

    logic               bitSum;
    logic               carryNext;
    logic [WIDTH-1:0]   sumShiftNext;

    // Full-adder cell operating on the current LSBs and the carry flop.
    always_comb begin
        bitSum    = opA_q[0] ^ opB_q[0] ^ carry_q;
        carryNext = (opA_q[0] & opB_q[0]) |
                    (opA_q[0] & carry_q)  |
                    (opB_q[0] & carry_q);
    end

    // The partial sum register only holds the first WIDTH-1 bits; the last
    // bit goes straight into the result register together with them, so the
    // combined vector is both the shifted partial sum and the final result.
    always_comb begin
        sumShiftNext = {bitSum, sumShift_q};
    end

    // Next-state and datapath control. Everything holds by default; only the
    // accept edge, each SHIFT cycle and the result handshake change state.
    always_comb begin
        state_d    = state_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        carry_d    = carry_q;
        bitCnt_d   = bitCnt_q;
        sumShift_d = sumShift_q;
        sum_d      = sum_q;
        carryOut_d = carryOut_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_d  = SHIFT;
                    opA_d    = addend_a;
                    opB_d    = addend_b;
                    carry_d  = carry_in;
                    bitCnt_d = '0;
                end
            end

            SHIFT: begin
                opA_d      = opA_q >> 1;
                opB_d      = opB_q >> 1;
                carry_d    = carryNext;
                sumShift_d = sumShiftNext[WIDTH-1:1];
                bitCnt_d   = bitCnt_q + CW'(1);
                // On the MSB cycle carry_q is the carry into the MSB, so the
                // overflow flag is simply that carry against the carry out.
                if (bitCnt_q == LAST_BIT) begin
                    state_d    = DONE;
                    sum_d      = sumShiftNext;
                    carryOut_d = carryNext;
                    overflow_d = carry_q ^ carryNext;
                end
            end

            DONE: begin
                if (sum_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    // and clears every register including the visible result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            carry_q    <= 1'b0;
            bitCnt_q   <= '0;
            sumShift_q <= '0;
            sum_q      <= '0;
            carryOut_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            carry_q    <= carry_d;
            bitCnt_q   <= bitCnt_d;
            sumShift_q <= sumShift_d;
            sum_q      <= sum_d;
            carryOut_q <= carryOut_d;
            overflow_q <= overflow_d;
        end
    end

    // Handshake flags decode straight from the state register; the result
    // outputs come from their own registers so they stay put while the next
    // operation is being shifted.
    always_comb begin
        start_ready = (state_q == IDLE);
        sum_valid   = (state_q == DONE);
        sum         = sum_q;
        carry_out   = carryOut_q;
        overflow    = overflow_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder (WIDTH = 8). A behavioural model
// computes every result with plain integer arithmetic and tracks the
// handshake timing as a cycle countdown; a compare process checks all DUT
// outputs against it on every falling edge. Directed cases pin literal
// values, latency, backpressure and asynchronous reset, then a randomized
// phase exercises arbitrary handshake patterns.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] addend_a = '0;
    logic [WIDTH-1:0] addend_b = '0;
    logic             carry_in = 1'b0;
    logic             sum_valid;
    logic             sum_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    int compared   = 0;
    int mismatched = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .addend_a    (addend_a),
        .addend_b    (addend_b),
        .carry_in    (carry_in),
        .sum_valid   (sum_valid),
        .sum_ready   (sum_ready),
        .sum         (sum),
        .carry_out   (carry_out),
        .overflow    (overflow)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Single point where every comparison is counted and reported.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Reference arithmetic: {overflow, carry_out, sum} from integer addition
    // and the sign rule (same-sign operands giving a different-sign result).
    function automatic logic [WIDTH+1:0] modelAdd(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic cin);
        int unsigned      total;
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
        total = int'(a) + int'(b) + int'(cin);
        s     = total[WIDTH-1:0];
        co    = total[WIDTH];
        ov    = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        return {ov, co, s};
    endfunction

    // Behavioural model of the handshake timing: idle, busy for WIDTH edges,
    // then holding the result until consumed.
    logic             mIdle   = 1'b1;
    logic             mDone   = 1'b0;
    int               mCnt    = 0;
    logic [WIDTH-1:0] expSum  = '0;
    logic             expCo   = 1'b0;
    logic             expOv   = 1'b0;
    logic [WIDTH-1:0] pendSum = '0;
    logic             pendCo  = 1'b0;
    logic             pendOv  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mIdle  <= 1'b1;
            mDone  <= 1'b0;
            mCnt   <= 0;
            expSum <= '0;
            expCo  <= 1'b0;
            expOv  <= 1'b0;
        end else if (mIdle) begin
            if (start_valid) begin
                {pendOv, pendCo, pendSum} <= modelAdd(addend_a, addend_b, carry_in);
                mIdle <= 1'b0;
                mCnt  <= WIDTH;
            end
        end else if (mCnt > 0) begin
            mCnt <= mCnt - 1;
            if (mCnt == 1) begin
                mDone  <= 1'b1;
                expSum <= pendSum;
                expCo  <= pendCo;
                expOv  <= pendOv;
            end
        end else if (mDone && sum_ready) begin
            mDone <= 1'b0;
            mIdle <= 1'b1;
        end
    end

    // Continuous compare against the model on every falling edge.
    always @(negedge clk) begin
        checkOutput("start_ready vs model", start_ready, mIdle);
        checkOutput("sum_valid vs model",   sum_valid,   mDone);
        checkOutput("sum vs model",         sum,         expSum);
        checkOutput("carry_out vs model",   carry_out,   expCo);
        checkOutput("overflow vs model",    overflow,    expOv);
    end

    // Offer one operand pair and complete the accept edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin);
        int guard = 0;
        @(negedge clk);
        while (!start_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!start_ready) begin
            checkOutput("start_ready wait timeout", start_ready, 1);
        end
        addend_a    = a;
        addend_b    = b;
        carry_in    = cin;
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    // Count edges from the accept edge until sum_valid is seen.
    task automatic waitResult(output int cycles);
        cycles = 0;
        while (!sum_valid && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic [WIDTH-1:0] eSum,
                         input logic eCo, input logic eOv);
        int cycles;
        applyStimulus(a, b, cin);
        waitResult(cycles);
        checkOutput("latency", cycles, WIDTH);
        checkOutput("sum literal", sum, eSum);
        checkOutput("carry_out literal", carry_out, eCo);
        checkOutput("overflow literal", overflow, eOv);
    endtask

    task automatic consumeResult();
        @(negedge clk);
        sum_ready = 1'b1;
        @(posedge clk);
        #1 sum_ready = 1'b0;
        checkOutput("sum_valid after handshake", sum_valid, 0);
        checkOutput("start_ready after handshake", start_ready, 1);
    endtask

    function automatic logic [WIDTH-1:0] randOperand();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b0, {(WIDTH-1){1'b1}}};
            3:       v = {1'b1, {(WIDTH-1){1'b0}}};
            default: v = WIDTH'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        int cycles;
        rst_n = 1'b0;

        // Reset values while reset is held
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset start_ready", start_ready, 1);
        checkOutput("reset sum_valid",   sum_valid,   0);
        checkOutput("reset sum",         sum,         0);
        checkOutput("reset carry_out",   carry_out,   0);
        checkOutput("reset overflow",    overflow,    0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pin the reference arithmetic with hand-computed values
        checkOutput("model 7F+01+0", modelAdd(8'h7F, 8'h01, 1'b0), 10'h280);
        checkOutput("model FF+FF+1", modelAdd(8'hFF, 8'hFF, 1'b1), 10'h1FF);
        checkOutput("model 80+80+0", modelAdd(8'h80, 8'h80, 1'b0), 10'h300);

        // Basic add, latency check inside runOp
        runOp(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
        consumeResult();
        runOp(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        consumeResult();
        runOp(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        consumeResult();

        // Backpressure: 20 cycles held, a start pulse in the middle ignored
        runOp(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) begin
                addend_a    = 8'h11;
                addend_b    = 8'h22;
                start_valid = 1'b1;
            end else begin
                start_valid = 1'b0;
            end
            checkOutput("backpressure sum",         sum,         8'h00);
            checkOutput("backpressure carry_out",   carry_out,   1);
            checkOutput("backpressure overflow",    overflow,    1);
            checkOutput("backpressure sum_valid",   sum_valid,   1);
            checkOutput("backpressure start_ready", start_ready, 0);
        end
        start_valid = 1'b0;
        consumeResult();

        // All-ones with carry-in; operand change after accept has no effect
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        addend_a = 8'h00;
        addend_b = 8'h00;
        carry_in = 1'b0;
        waitResult(cycles);
        checkOutput("latency all-ones", cycles, WIDTH);
        checkOutput("all-ones sum",       sum,       8'hFF);
        checkOutput("all-ones carry_out", carry_out, 1);
        checkOutput("all-ones overflow",  overflow,  0);
        consumeResult();

        // Asynchronous reset during the 4th SHIFT cycle
        applyStimulus(8'h55, 8'h0F, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async reset start_ready", start_ready, 1);
        checkOutput("async reset sum_valid",   sum_valid,   0);
        checkOutput("async reset sum",         sum,         0);
        checkOutput("async reset carry_out",   carry_out,   0);
        checkOutput("async reset overflow",    overflow,    0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        runOp(8'h10, 8'h22, 1'b0, 8'h32, 1'b0, 1'b0);
        consumeResult();

        // Randomized handshake and operand traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start_valid = 1'($urandom_range(0, 1));
            addend_a    = randOperand();
            addend_b    = randOperand();
            carry_in    = 1'($urandom_range(0, 1));
            sum_ready   = ($urandom_range(0, 3) != 0);
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end

        // Drain
        @(negedge clk);
        start_valid = 1'b0;
        sum_ready   = 1'b1;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
